sprite_eval: RTL and testbench
==============================

Name: sprite_eval

Overview:
- Per-scanline sprite evaluation controller for the PPU.
- On `start`, it clears the 32-byte secondary OAM to 0xFF, then scans all 64 primary-OAM entries through OAM read port B.
- It copies up to 8 in-range sprites (4 bytes each) into secondary OAM and flags overflow and sprite-0 presence.
- The sprite pattern-fetch stage consumes secondary OAM and the result flags during HBLANK.

Parameters:
- NUM_SPR, 64, primary OAM entries scanned (must be a power of 2).
- MAX_SPR, 8, secondary OAM capacity in sprites.

Ports:
- clk, input, 1, evaluation clock (vga_clk domain).
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse that begins evaluation; ignored while busy.
- abort, input, 1, synchronous; returns the block to IDLE without a done pulse.
- scanline, input, 8, target scanline; sampled on start.
- tall, input, 1, 8x16 sprite mode (PPUCTRL[5]); sampled on start.
- oam_addr, output, 8, primary OAM read address; combinational from state/counters.
- oam_data, input, 8, primary OAM read data; valid the cycle after oam_addr is presented.
- sec_wr, output, 1, secondary OAM write enable.
- sec_addr, output, 5, secondary OAM write address.
- sec_data, output, 8, secondary OAM write data.
- busy, output, 1, high from the cycle after an accepted start until DONE.
- done, output, 1, single-cycle pulse in the DONE state.
- sprite_count, output, 4, number of sprites copied (0..8).
- overflow, output, 1, a 9th in-range sprite was found.
- spr0_found, output, 1, OAM entry 0 is in range and was copied.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; busy=0, done=0, sec_wr=0, sprite_count=0, overflow=0, spr0_found=0, oam_addr=0, sec_addr=0, sec_data=0.
- Reset mid-operation leaves secondary OAM partially written; this is legal.
- States: IDLE, CLR, RDY, CHK, CPY, DONE.
- IDLE:
  - start=1 latches scanline and tall, clears sprite_count, overflow and spr0_found, and sets n=0, i=0.
  - Next state is CLR.
- CLR (32 cycles):
  - sec_wr=1, sec_addr=i, sec_data=0xFF; i increments.
  - After i=31, go to RDY.
- RDY (1 cycle): oam_addr={n,2'b00}. Next state is CHK.
- CHK:
  - oam_data holds Y.
  - d = {1'b0,scanline} - {1'b0,Y}, 9-bit. in_range = (d[8]==0) && (d[7:0] < (tall ? 16 : 8)). Y > scanline therefore never hits.
  - in_range and sprite_count<MAX_SPR:
    - sec_wr=1, sec_addr={sprite_count[2:0],2'b00}, sec_data=Y.
    - oam_addr={n,2'b01}; k=1; go to CPY.
    - If n==0, set spr0_found=1.
  - in_range and sprite_count==MAX_SPR: overflow=1; go to DONE. No further scanning.
  - Not in range: n increments. If n was NUM_SPR-1, go to DONE; otherwise go to RDY.
- CPY (exactly 3 cycles, k=1..3):
  - sec_wr=1, sec_addr={sprite_count[2:0],k[1:0]}, sec_data=oam_data (raw copy, attributes unmodified).
  - oam_addr={n,k+1} while k<3.
  - At k=3: sprite_count increments. n increments. If n was NUM_SPR-1, go to DONE; otherwise go to RDY.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE.
  - sprite_count, overflow and spr0_found hold until the next accepted start.
- sec_wr=0 in IDLE, RDY, DONE, and in CHK when no copy occurs.
- oam_addr=0 in IDLE, CLR and DONE.
- start asserted while busy is ignored and does not restart.
- start and done in the same cycle: the start is ignored; it is accepted only in IDLE.
- abort in any non-IDLE state:
  - Next state is IDLE; no done pulse.
  - Flags keep their partial values.
  - abort has priority over all transitions, including start in IDLE.
- n is a log2(NUM_SPR)-bit counter and wraps from 63 to 0; the wrap terminates the scan.
- Worst-case latency from start to done: 1 + 32 + 64·2 + 8·3 + 1 = 186 cycles. This fits within HBLANK.

Test Plan:
- All OAM Y=0xFF, scanline=10, start:
  - 32 CLR writes of 0xFF.
  - done at cycle 162; sprite_count=0, overflow=0, spr0_found=0.
- Entry 0 = {Y=5,0x11,0x22,0x33}, others Y=0xF0, scanline=12, tall=0:
  - sec[0..3]={5,0x11,0x22,0x33}; sprite_count=1, spr0_found=1.
  - Boundary checks: Y=4 with scanline=12 is a miss (d=8). Same Y with tall=1 is a hit.
- Entries 3..12 with Y=20, scanline=22:
  - Entries 3..10 are copied to sec slots 0..7 in order.
  - Overflow asserts when entry 11 is checked; done follows; sprite_count=8.
- Entry 63 only in range:
  - Copied to slot 0; n wraps; done asserted; spr0_found=0.
- Reset and abort:
  - reset_n low during CPY: all outputs return to reset values immediately (asynchronously).
  - abort during CLR: returns to IDLE with no done pulse; a subsequent start runs a full evaluation.
- Start while busy:
  - A second start at cycle 50 has no effect.
  - done fires exactly once at the expected cycle count.

Source files
------------

// File: rtl/sprite_eval_if.sv
// OAM-side bus of the sprite evaluator: primary OAM read port B and secondary OAM write port.
interface sprite_eval_if;
    logic [7:0] oam_addr;
    logic [7:0] oam_data;
    logic       sec_wr;
    logic [4:0] sec_addr;
    logic [7:0] sec_data;

    modport master (
        output oam_addr,
        output sec_wr,
        output sec_addr,
        output sec_data,
        input  oam_data
    );

    modport slave (
        input  oam_addr,
        input  sec_wr,
        input  sec_addr,
        input  sec_data,
        output oam_data
    );
endinterface

// File: rtl/sprite_eval.sv
// Per-scanline sprite evaluation: clears secondary OAM, scans primary OAM and
// copies up to MAX_SPR in-range sprites, reporting count, overflow and sprite-0 hit.
module sprite_eval #(
    parameter int unsigned NUM_SPR = 64,
    parameter int unsigned MAX_SPR = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          scanline,
    input  logic                tall,
    sprite_eval_if.master       oam,
    output logic                busy,
    output logic                done,
    output logic [3:0]          sprite_count,
    output logic                overflow,
    output logic                spr0_found
);

    localparam int unsigned NW = $clog2(NUM_SPR);
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RDY,
        S_CHK,
        S_CPY,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      i_q, i_d;
    logic [NW-1:0]   n_q, n_d;
    logic [1:0]      k_q, k_d;
    logic [7:0]      line_q, line_d;
    logic            tall_q, tall_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            spr0_q, spr0_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [7:0]      oam_addr_c;
    logic            sec_wr_c;
    logic [4:0]      sec_addr_c;
    logic [7:0]      sec_data_c;

    logic [8:0]      diff;
    logic            in_range;
    logic            last_spr;
    logic            has_room;

    // Y above the scanline borrows into bit 8 and is never in range.
    assign diff     = {1'b0, line_q} - {1'b0, oam.oam_data};
    assign in_range = ~diff[8] && (diff[7:0] < (tall_q ? 8'd16 : 8'd8));
    assign last_spr = (n_q == NW'(NUM_SPR - 1));
    assign has_room = (cnt_q < CW'(MAX_SPR));

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        n_d        = n_q;
        k_d        = k_q;
        line_d     = line_q;
        tall_d     = tall_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        spr0_d     = spr0_q;
        oam_addr_c = 8'd0;
        sec_wr_c   = 1'b0;
        sec_addr_c = 5'd0;
        sec_data_c = 8'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    line_d  = scanline;
                    tall_d  = tall;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    spr0_d  = 1'b0;
                    n_d     = '0;
                    i_d     = 5'd0;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                sec_wr_c   = 1'b1;
                sec_addr_c = i_q;
                sec_data_c = 8'hFF;
                i_d        = 5'(i_q + 5'd1);
                if (i_q == 5'd31) begin
                    state_d = S_RDY;
                end
            end
            S_RDY: begin
                oam_addr_c = 8'({n_q, 2'b00});
                state_d    = S_CHK;
            end
            S_CHK: begin
                if (in_range && has_room) begin
                    sec_wr_c   = 1'b1;
                    sec_addr_c = {cnt_q[2:0], 2'b00};
                    sec_data_c = oam.oam_data;
                    oam_addr_c = 8'({n_q, 2'b01});
                    k_d        = 2'd1;
                    state_d    = S_CPY;
                    if (n_q == '0) begin
                        spr0_d = 1'b1;
                    end
                end else if (in_range) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    n_d     = NW'(n_q + 1'b1);
                    state_d = last_spr ? S_DONE : S_RDY;
                end
            end
            S_CPY: begin
                sec_wr_c   = 1'b1;
                sec_addr_c = {cnt_q[2:0], k_q};
                sec_data_c = oam.oam_data;
                if (k_q != 2'd3) begin
                    oam_addr_c = 8'({n_q, 2'(k_q + 2'd1)});
                    k_d        = 2'(k_q + 2'd1);
                end else begin
                    cnt_d   = CW'(cnt_q + 1'b1);
                    n_d     = NW'(n_q + 1'b1);
                    state_d = last_spr ? S_DONE : S_RDY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every transition and leaves the result flags untouched.
        if (abort) begin
            state_d = S_IDLE;
            line_d  = line_q;
            tall_d  = tall_q;
            cnt_d   = cnt_q;
            ovf_d   = ovf_q;
            spr0_d  = spr0_q;
        end

        busy_d = (state_d == S_CLR) || (state_d == S_RDY) ||
                 (state_d == S_CHK) || (state_d == S_CPY);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            i_q     <= 5'd0;
            n_q     <= '0;
            k_q     <= 2'd0;
            line_q  <= 8'd0;
            tall_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            spr0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            n_q     <= n_d;
            k_q     <= k_d;
            line_q  <= line_d;
            tall_q  <= tall_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            spr0_q  <= spr0_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oam.oam_addr = oam_addr_c;
    assign oam.sec_wr   = sec_wr_c;
    assign oam.sec_addr = sec_addr_c;
    assign oam.sec_data = sec_data_c;

    assign busy         = busy_q;
    assign done         = done_q;
    assign sprite_count = cnt_q;
    assign overflow     = ovf_q;
    assign spr0_found   = spr0_q;

endmodule

// File: tb/tb_sprite_eval.sv
// Directed bench for sprite_eval: OAM model, write scoreboard and result/latency checks.
module tb_sprite_eval;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic [7:0] scanline = 8'd0;
    logic       tall     = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] sprite_count;
    logic       overflow;
    logic       spr0_found;

    sprite_eval_if bus();

    sprite_eval #(.NUM_SPR(64), .MAX_SPR(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .scanline     (scanline),
        .tall         (tall),
        .oam          (bus),
        .busy         (busy),
        .done         (done),
        .sprite_count (sprite_count),
        .overflow     (overflow),
        .spr0_found   (spr0_found)
    );

    always #5 clk = ~clk;

    // Primary OAM: synchronous read, data valid the cycle after the address.
    logic [7:0] oam_mem [256];
    always @(posedge clk) bus.oam_data <= oam_mem[bus.oam_addr];

    logic [12:0] obs_q [$];
    int          done_seen = 0;
    always @(posedge clk) begin
        if (bus.sec_wr) obs_q.push_back({bus.sec_addr, bus.sec_data});
        if (done) done_seen++;
    end

    int          checks = 0;
    int          errors = 0;
    logic [12:0] exp_w [$];
    int          exp_cnt;
    int          exp_lat;
    bit          exp_ovf;
    bit          exp_spr0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] y);
        for (int n = 0; n < 64; n++) begin
            oam_mem[8'(4*n)] = y;
            for (int b = 1; b < 4; b++) oam_mem[8'(4*n+b)] = 8'(n*3 + b*64);
        end
    endtask

    // Reference: expected secondary-OAM writes, flags and start-to-done latency.
    task automatic model(input logic [7:0] line, input logic t);
        int l, y, lim, nchk, cp;
        l = int'(line);
        lim = t ? 16 : 8;
        nchk = 0;
        cp = 0;
        exp_w.delete();
        exp_ovf = 1'b0;
        exp_spr0 = 1'b0;
        for (int a = 0; a < 32; a++) exp_w.push_back({5'(a), 8'hFF});
        for (int n = 0; n < 64; n++) begin
            y = int'(oam_mem[8'(4*n)]);
            nchk++;
            if (l >= y && (l - y) < lim) begin
                if (cp == 8) begin
                    exp_ovf = 1'b1;
                    break;
                end
                for (int b = 0; b < 4; b++) exp_w.push_back({5'(cp*4+b), oam_mem[8'(4*n+b)]});
                if (n == 0) exp_spr0 = 1'b1;
                cp++;
            end
        end
        exp_cnt = cp;
        exp_lat = 1 + 32 + 2*nchk + 3*cp + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One evaluation; the cycle carrying start is cycle 1. again_at re-pulses start mid-run.
    task automatic run(input string tag, input logic [7:0] line, input logic t, input int again_at);
        int base, dbase, cyc;
        bit seen;
        model(line, t);
        base  = obs_q.size();
        dbase = done_seen;
        @(negedge clk);
        scanline = line;
        tall     = t;
        start    = 1'b1;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            step();
            start = 1'b0;
            cyc++;
            if (cyc == again_at) start = 1'b1;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_count"}, 32'(sprite_count), 32'(exp_cnt));
        chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, "_spr0"}, 32'(spr0_found), 32'(exp_spr0));
        step();
        chk({tag, "_done_single"}, 32'(done), 32'd0);
        chk({tag, "_done_once"}, 32'(done_seen - dbase), 32'd1);
        chk({tag, "_count_hold"}, 32'(sprite_count), 32'(exp_cnt));
        chk({tag, "_nwrites"}, 32'(obs_q.size() - base), 32'(exp_w.size()));
        for (int j = 0; j < exp_w.size(); j++) begin
            if (base + j < obs_q.size())
                chk({tag, "_secwr"}, 32'(obs_q[base+j]), 32'(exp_w[j]));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_sec_wr"}, 32'(bus.sec_wr), 32'd0);
        chk({tag, "_sec_addr"}, 32'(bus.sec_addr), 32'd0);
        chk({tag, "_sec_data"}, 32'(bus.sec_data), 32'd0);
        chk({tag, "_oam_addr"}, 32'(bus.oam_addr), 32'd0);
        chk({tag, "_count"}, 32'(sprite_count), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_spr0"}, 32'(spr0_found), 32'd0);
    endtask

    initial begin
        int dbase;
        fill(8'hFF);
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // No sprite in range.
        fill(8'hFF);
        run("empty", 8'd10, 1'b0, 0);
        chk("empty_lat_const", 32'(exp_lat), 32'd162);

        // Sprite 0 in range with a known payload.
        fill(8'hF0);
        oam_mem[0] = 8'd5; oam_mem[1] = 8'h11; oam_mem[2] = 8'h22; oam_mem[3] = 8'h33;
        run("spr0", 8'd12, 1'b0, 0);
        chk("spr0_count_const", 32'(sprite_count), 32'd1);
        chk("spr0_flag_const", 32'(spr0_found), 32'd1);

        // d = 8 misses in 8x8 mode and hits in 8x16 mode.
        oam_mem[0] = 8'd4;
        run("y4_short", 8'd12, 1'b0, 0);
        chk("y4_short_miss", 32'(sprite_count), 32'd0);
        run("y4_tall", 8'd12, 1'b1, 0);
        chk("y4_tall_hit", 32'(sprite_count), 32'd1);

        // Ten candidates: eight copied, the ninth raises overflow.
        fill(8'hF0);
        for (int n = 3; n <= 12; n++) oam_mem[8'(4*n)] = 8'd20;
        run("ovf", 8'd22, 1'b0, 0);
        chk("ovf_flag_const", 32'(overflow), 32'd1);
        chk("ovf_count_const", 32'(sprite_count), 32'd8);

        // Start pulse during the run is ignored.
        run("restart", 8'd22, 1'b0, 50);

        // Only the last entry in range; the scan ends on the wrap of n.
        fill(8'hF0);
        oam_mem[252] = 8'd100;
        run("last", 8'd105, 1'b0, 0);
        chk("last_spr0_const", 32'(spr0_found), 32'd0);

        // Abort during clear: back to idle, no done pulse.
        fill(8'hF0);
        oam_mem[0] = 8'd5;
        @(negedge clk);
        scanline = 8'd12;
        tall     = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("abort_busy_before", 32'(busy), 32'd1);
        dbase = done_seen;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy_after", 32'(busy), 32'd0);
        chk("abort_idle_sec_wr", 32'(bus.sec_wr), 32'd0);
        repeat (5) step();
        chk("abort_no_done", 32'(done_seen - dbase), 32'd0);
        run("post_abort", 8'd12, 1'b0, 0);

        // Asynchronous reset in the middle of a copy.
        @(negedge clk);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (35) step();
        chk("cpy_before_reset_wr", 32'(bus.sec_wr), 32'd1);
        chk("cpy_before_reset_spr0", 32'(spr0_found), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        run("post_reset", 8'd12, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
